spi_slave_shift_register: RTL and testbench

// - Slave-side counterpart of the APB SPI master shift register: serialises a byte onto miso and deserialises mosi.
// - Samples external sclk/ss/mosi in the pclk domain, supports all four CPOL/CPHA modes and MSB/LSB-first order.
// - Supports back-to-back bytes within one ss assertion.
// - Sits between the SPI pins and an APB slave register front-end: tx byte in, rx byte out, status flags.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_shift_register.sv | 170 +++++++++++++++++
 tb/tb_spi_slave_shift_register.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI slave shift register: mode encodings, FSM states, width default.
package spi_pkg;
  localparam int DATA_WIDTH_DEF = 8;

  // Encoded as {cpol, cpha}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// N-flop pin synchroniser with single-cycle rise/fall pulses on the synced value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_slave_shift_register.sv
// SPI slave byte shifter in the pclk domain: oversampled pins, all CPOL/CPHA modes,
// MSB/LSB order, single-entry tx buffer and rx holding register with sticky flags.
module spi_slave_shift_register
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = {DATA_WIDTH{1'b1}}
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsbfe,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  input  logic                  clr_status,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  busy
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(pclk), .rst(preset), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  // ss idles high so reset must not fabricate a falling edge
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(pclk), .rst(preset), .d(ss), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_t            state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d, rx_next;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_full_q, tx_full_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic                  miso_oe_q, miso_oe_d;

  spi_mode_t mode;
  logic      sample_on_lead, lead, trail, samp_edge, shift_edge;
  logic      frame_start, in_frame, load, shift, sample, last_bit;

  assign mode           = spi_mode_t'({cpol, cpha});
  assign sample_on_lead = (mode == MODE0) || (mode == MODE2);
  assign lead           = cpol ? sclk_fall : sclk_rise;
  assign trail          = cpol ? sclk_rise : sclk_fall;
  assign samp_edge      = sample_on_lead ? lead  : trail;
  assign shift_edge     = sample_on_lead ? trail : lead;

  assign frame_start = (state_q == IDLE) && ss_fall;
  assign in_frame    = (state_q == ACTIVE) && !ss_rise;
  // A shift edge at bit_cnt==0 is a byte boundary: reload instead of shifting
  assign load     = (frame_start && sample_on_lead) || (in_frame && shift_edge && bit_cnt_q == '0);
  assign shift    = in_frame && shift_edge && bit_cnt_q != '0;
  assign sample   = in_frame && samp_edge;
  assign last_bit = sample && (bit_cnt_q == LAST);

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    overrun_d   = overrun_q  & ~clr_status;
    underrun_d  = underrun_q & ~clr_status;
    rx_next     = lsbfe ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]} : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};

    if (frame_start) state_d = ACTIVE;
    if (state_q == ACTIVE && ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end

    if (rx_ack) rx_valid_d = 1'b0;
    if (sample) begin
      rx_sh_d = rx_next;
      if (last_bit) begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
        bit_cnt_d  = '0;
        if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end

    if (shift) shreg_d = lsbfe ? (shreg_q >> 1) : (shreg_q << 1);
    if (load) begin
      if (tx_full_q) begin
        shreg_d   = tx_buf_q;
        tx_full_d = 1'b0;
      end else begin
        shreg_d    = DEFAULT_TX;
        underrun_d = 1'b1;
      end
    end
    // Uses the pre-load fullness, so a write coinciding with an empty load lands for the next byte
    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    miso_oe_d = (state_d == ACTIVE);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign miso     = lsbfe ? shreg_q[0] : shreg_q[DATA_WIDTH-1];
  assign miso_oe  = miso_oe_q;
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;
  assign busy     = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_shift_register.sv
// Directed bench: behavioural SPI master drives the pins, expected bytes and flags are hand-derived.
module tb_spi_slave_shift_register;
  localparam int HALF = 8;

  logic       pclk = 1'b0;
  logic       preset, cpol, cpha, lsbfe, sclk, ss, mosi;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, rx_ack, clr_status;
  logic       overrun, underrun, busy;
  logic [7:0] tx_data, rx_data, mi, mi2;
  int         n_chk = 0;
  int         n_fail = 0;

  spi_slave_shift_register #(.DATA_WIDTH(8), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
    .pclk(pclk), .preset(preset), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .clr_status(clr_status), .overrun(overrun), .underrun(underrun), .busy(busy)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    cpol = pol; cpha = pha; lsbfe = lsb; sclk = pol;
    cyc(4);
  endtask

  task automatic wr_tx(input logic [7:0] v);
    tx_data = v; tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low;  ss = 1'b0; cyc(HALF); endtask
  task automatic ss_high; ss = 1'b1; cyc(HALF); endtask
  task automatic ack;     rx_ack = 1'b1; cyc(1); rx_ack = 1'b0; cyc(1); endtask
  task automatic clr;     clr_status = 1'b1; cyc(1); clr_status = 1'b0; cyc(1); endtask

  // Master side: drives nbits of mo, returns the miso bits it sampled
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] got);
    int idx;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[idx]; cyc(HALF);
        sclk = ~cpol; got[idx] = miso; cyc(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = mo[idx]; cyc(HALF);
        sclk = cpol; got[idx] = miso; cyc(HALF);
      end
    end
    cyc(HALF);
  endtask

  initial begin
    preset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0; clr_status = 1'b0;
    cyc(3);
    preset = 1'b0;
    cyc(2);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_busy", busy, 0);

    // Mode 0, MSB first
    set_mode(1'b0, 1'b0, 1'b0);
    wr_tx(8'hA5);
    chk("m0_tx_full", tx_ready, 0);
    ss_low;
    chk("m0_busy", busy, 1);
    chk("m0_miso_oe", miso_oe, 1);
    chk("m0_tx_ready_after_load", tx_ready, 1);
    chk("m0_first_bit", miso, 1);
    xfer(8'h3C, 8, mi);
    chk("m0_miso_byte", mi, 8'hA5);
    chk("m0_rx_data", rx_data, 8'h3C);
    chk("m0_rx_valid", rx_valid, 1);
    chk("m0_boundary_underrun", underrun, 1);
    ss_high;
    chk("m0_idle_busy", busy, 0);
    chk("m0_idle_miso_oe", miso_oe, 0);
    ack;
    chk("m0_ack", rx_valid, 0);
    clr;
    chk("m0_clr_underrun", underrun, 0);

    // Mode 3, LSB first
    set_mode(1'b1, 1'b1, 1'b1);
    wr_tx(8'h01);
    ss_low;
    xfer(8'h80, 8, mi);
    chk("m3_first_bit", mi[0], 1);
    chk("m3_miso_byte", mi, 8'h01);
    chk("m3_rx_data", rx_data, 8'h80);
    chk("m3_no_underrun", underrun, 0);
    ss_high;
    ack;

    // Two bytes in one frame, second tx written mid byte 1, no ack
    set_mode(1'b0, 1'b0, 1'b0);
    wr_tx(8'h11);
    ss_low;
    fork
      xfer(8'h5A, 8, mi);
      begin cyc(30); wr_tx(8'h22); end
    join
    chk("bb_miso_byte1", mi, 8'h11);
    chk("bb_rx_valid1", rx_valid, 1);
    chk("bb_no_overrun1", overrun, 0);
    xfer(8'hC3, 8, mi2);
    chk("bb_miso_byte2", mi2, 8'h22);
    chk("bb_overrun", overrun, 1);
    chk("bb_rx_data2", rx_data, 8'hC3);
    ss_high;
    ack;
    clr;
    chk("bb_clr_overrun", overrun, 0);

    // Underrun, mode 1
    set_mode(1'b0, 1'b1, 1'b0);
    chk("ur_pre", underrun, 0);
    ss_low;
    xfer(8'h42, 8, mi);
    chk("ur_miso_byte", mi, 8'hFF);
    chk("ur_underrun", underrun, 1);
    chk("ur_overrun", overrun, 0);
    chk("ur_rx_data", rx_data, 8'h42);
    ss_high;
    ack;
    clr;
    chk("ur_clr_underrun", underrun, 0);
    chk("ur_clr_overrun", overrun, 0);

    // Abort after 4 bits, then a clean frame
    set_mode(1'b0, 1'b0, 1'b0);
    wr_tx(8'h5A);
    ss_low;
    xfer(8'hE7, 4, mi);
    ss_high;
    chk("ab_rx_valid", rx_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_miso_oe", miso_oe, 0);
    chk("ab_rx_data_kept", rx_data, 8'h42);
    wr_tx(8'h96);
    ss_low;
    xfer(8'h69, 8, mi);
    chk("ab_miso_byte", mi, 8'h96);
    chk("ab_rx_data", rx_data, 8'h69);
    chk("ab_rx_valid_full", rx_valid, 1);
    ss_high;

    // Reset mid-byte in mode 1
    set_mode(1'b0, 1'b1, 1'b0);
    wr_tx(8'h33);
    ss_low;
    fork
      xfer(8'hF0, 8, mi);
      begin
        cyc(40);
        preset = 1'b1; cyc(2); preset = 1'b0; cyc(1);
        chk("pr_miso", miso, 0);
        chk("pr_miso_oe", miso_oe, 0);
        chk("pr_tx_ready", tx_ready, 1);
        chk("pr_rx_data", rx_data, 0);
        chk("pr_rx_valid", rx_valid, 0);
        chk("pr_overrun", overrun, 0);
        chk("pr_underrun", underrun, 0);
        chk("pr_busy", busy, 0);
      end
    join
    ss_high;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
